// File: rtl/resp_checker.sv
// Response checker: compares observed vs expected words over a counted sweep,
// counts mismatches, records the first failing index and folds data into a MISR.
// Optional per-bit compare mask enabled by defining RESP_CHECKER_MASK_EN.
module resp_checker #(
  parameter int unsigned          WIDTH     = 32,
  parameter int unsigned          IDX_W     = 32,
  parameter logic [WIDTH-1:0]     MISR_POLY = 32'h04C11DB7,
  parameter logic [WIDTH-1:0]     MISR_SEED = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [IDX_W-1:0] num_vec,
  input  logic             obs_valid,
  input  logic [WIDTH-1:0] obs_data,
  input  logic [WIDTH-1:0] exp_data,
`ifdef RESP_CHECKER_MASK_EN
  input  logic [WIDTH-1:0] exp_mask,
`endif
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      err_count,
  output logic [IDX_W-1:0] first_err_idx,
  output logic [WIDTH-1:0] signature
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] num_q, num_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [15:0]      err_q, err_d;
  logic [IDX_W-1:0] first_q, first_d;
  logic [WIDTH-1:0] sig_q, sig_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             mism;

`ifdef RESP_CHECKER_MASK_EN
  assign mism = ((obs_data ^ exp_data) & exp_mask) != '0;
`else
  assign mism = obs_data != exp_data;
`endif

  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    idx_d   = idx_q;
    err_d   = err_q;
    first_d = first_q;
    sig_d   = sig_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          idx_d   = '0;
          err_d   = '0;
          first_d = '1;
          sig_d   = MISR_SEED;
          if (num_vec == '0) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = 1'b1;
          end else begin
            state_d = RUN;
            num_d   = num_vec;
            busy_d  = 1'b1;
            done_d  = 1'b0;
            pass_d  = 1'b0;
          end
        end
      end
      RUN: begin
        if (obs_valid) begin
          if (mism) begin
            if (err_q != '1) err_d = err_q + 16'd1;
            if (err_q == '0) first_d = idx_q;
          end
          sig_d = {sig_q[WIDTH-2:0], 1'b0} ^ (sig_q[WIDTH-1] ? MISR_POLY : '0) ^ obs_data;
          idx_d = idx_q + IDX_W'(1);
          // pass must reflect this final beat's compare, hence err_d not err_q
          if (idx_q == num_q - IDX_W'(1)) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_d == '0);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      num_q   <= '0;
      idx_q   <= '0;
      err_q   <= '0;
      first_q <= '1;
      sig_q   <= MISR_SEED;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      first_q <= first_d;
      sig_q   <= sig_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign err_count     = err_q;
  assign first_err_idx = first_q;
  assign signature     = sig_q;

endmodule
